// File: rtl/div32_iter_pkg.sv
// Shared definitions for the iterative RV32M divider: default width and FSM states.
package div32_iter_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract when it fits.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] prem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] prem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // No borrow out of the widened subtraction means shifted >= divisor.
    always_comb begin
        shifted   = {prem, dvd_msb};
        diff      = shifted - {1'b0, divisor};
        q_bit     = ~diff[XLEN];
        prem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div32_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// special cases (divide by zero, signed overflow) resolved in the accept cycle.
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] prem_q, prem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic            a_neg, b_neg, is_div0, is_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_prem;
    logic            step_q;

    div_step #(.XLEN(XLEN)) u_step (
        .prem      (prem_q),
        .dvd_msb   (dvd_q[XLEN-1]),
        .divisor   (dvs_q),
        .prem_next (step_prem),
        .q_bit     (step_q)
    );

    always_comb begin
        a_neg   = is_signed & a[XLEN-1];
        b_neg   = is_signed & b[XLEN-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        is_div0 = (b == '0);
        is_ovf  = is_signed && (a == INT_MIN) && (b == '1);

        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        quo_d   = quo_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (is_div0) begin
                        quo_d   = '1;
                        rem_d   = a;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_ovf) begin
                        quo_d   = INT_MIN;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        prem_d  = '0;
                        cnt_d   = CW'(XLEN - 1);
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prem_d = step_prem;
                dvd_d  = {dvd_q[XLEN-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                quo_d   = qneg_q ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -prem_q : prem_q;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_div32_iter.sv
// Scenario bench for div32_iter: expected results queued at start, compared at done.
module tb_div32_iter;

    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] quo, rem;

    always #5 clk = ~clk;

    div32_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quo       (quo),
        .rem       (rem)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model in RISC-V terms, independent of the restoring algorithm.
    function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        logic signed [31:0] sa, sbv;
        sa  = av;
        sbv = bv;
        lat = 34;
        if (bv == 32'd0) begin
            q = 32'hFFFF_FFFF; r = av; lat = 1;
        end else if (sv && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 1;
        end else if (sv) begin
            q = sa / sbv; r = sa % sbv;
        end else begin
            q = av / bv; r = av % bv;
        end
    endfunction

    // Drive start in the negedge before cycle 0; returns at the cycle-1 sample point.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                            input logic [31:0] eq, input logic [31:0] er, input int el, input bit push);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; is_signed = sv; start = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.lat = el;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; reports the cycle it appeared and whether busy stayed high.
    task automatic wait_done(input int cyc0, output int cyc, output bit seen, output bit busy_ok);
        cyc = cyc0; seen = 1'b0; busy_ok = 1'b1;
        while (cyc < 80 && !seen) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (quo !== 32'd0) begin n_fail++; $display("FAIL reset_quo: got %h expected 0", quo); end
        n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL reset_rem: got %h expected 0", rem); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_unsigned;
        int cyc; bit seen, bok; exp_t e;
        start_op(32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 34, 1'b1);
        wait_done(1, cyc, seen, bok);
        e = sb.pop_front();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL unsigned_done_seen: got none expected pulse"); end
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected %0d", cyc, e.lat); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL unsigned_busy: got low expected high in 1..%0d", e.lat); end
        n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL unsigned_quo: got %h expected %h", quo, e.q); end
        n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL unsigned_rem: got %h expected %h", rem, e.r); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL unsigned_after: got done=%b busy=%b expected 0/0", done, busy);
        end
        n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL unsigned_hold: got %h expected %h", quo, e.q); end
    endtask

    task automatic test_signed;
        int cyc; bit seen, bok; exp_t e;
        vec_t v[2];
        v[0] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
        v[1] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34};
        for (int i = 0; i < 2; i++) begin
            start_op(v[i].a, v[i].b, v[i].s, v[i].q, v[i].r, v[i].lat, 1'b1);
            wait_done(1, cyc, seen, bok);
            e = sb.pop_front();
            n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, cyc, e.lat); end
            n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL signed_quo[%0d]: got %h expected %h", i, quo, e.q); end
            n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL signed_rem[%0d]: got %h expected %h", i, rem, e.r); end
        end
    endtask

    task automatic test_div_zero;
        int cyc; bit seen, bok; exp_t e;
        for (int s = 0; s < 2; s++) begin
            start_op(32'd5, 32'd0, s[0], 32'hFFFF_FFFF, 32'd5, 1, 1'b1);
            wait_done(1, cyc, seen, bok);
            e = sb.pop_front();
            n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL div0_latency[s=%0d]: got %0d expected %0d", s, cyc, e.lat); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL div0_busy[s=%0d]: got low expected high", s); end
            n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL div0_quo[s=%0d]: got %h expected %h", s, quo, e.q); end
            n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL div0_rem[s=%0d]: got %h expected %h", s, rem, e.r); end
        end
    endtask

    task automatic test_overflow;
        int cyc; bit seen, bok; exp_t e;
        vec_t v[2];
        v[0] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1};
        v[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 34};
        for (int i = 0; i < 2; i++) begin
            start_op(v[i].a, v[i].b, v[i].s, v[i].q, v[i].r, v[i].lat, 1'b1);
            wait_done(1, cyc, seen, bok);
            e = sb.pop_front();
            n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL ovf_latency[%0d]: got %0d expected %0d", i, cyc, e.lat); end
            n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL ovf_quo[%0d]: got %h expected %h", i, quo, e.q); end
            n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL ovf_rem[%0d]: got %h expected %h", i, rem, e.r); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc; bit seen, bok; exp_t e;
        start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1'b1);
        repeat (9) @(negedge clk);
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, cyc, seen, bok);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, e.lat); end
        n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL b2b_quo: got %h expected %h", quo, e.q); end
        n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL b2b_rem: got %h expected %h", rem, e.r); end
        // Next start lands in cycle 35, the earliest accept slot.
        start_op(32'd1, 32'd1, 1'b0, 32'd1, 32'd0, 34, 1'b1);
        wait_done(1, cyc, seen, bok);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL b2b2_latency: got %0d expected %0d", cyc, e.lat); end
        n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL b2b2_quo: got %h expected %h", quo, e.q); end
        n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL b2b2_rem: got %h expected %h", rem, e.r); end
    endtask

    task automatic test_mid_reset;
        int cyc, pulses; bit seen, bok; exp_t e;
        start_op(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (quo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_quo: got %h expected 0", quo); end
        n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rem: got %h expected 0", rem); end
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", pulses); end
        start_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 1'b1);
        wait_done(1, cyc, seen, bok);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected %0d", cyc, e.lat); end
        n_checks++; if (quo !== e.q) begin n_fail++; $display("FAIL rst_next_quo: got %h expected %h", quo, e.q); end
        n_checks++; if (rem !== e.r) begin n_fail++; $display("FAIL rst_next_rem: got %h expected %h", rem, e.r); end
    endtask

    task automatic test_random;
        int cyc, el; bit seen, bok; exp_t e;
        logic [31:0] av, bv, eq, er; logic sv;
        for (int i = 0; i < 12; i++) begin
            av = $urandom;
            bv = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            sv = 1'($urandom_range(0, 1));
            ref_div(av, bv, sv, eq, er, el);
            start_op(av, bv, sv, eq, er, el, 1'b1);
            wait_done(1, cyc, seen, bok);
            e = sb.pop_front();
            n_checks++; if (cyc !== e.lat || !seen) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, cyc, e.lat); end
            n_checks++; if (quo !== e.q || rem !== e.r) begin
                n_fail++; $display("FAIL rand_result[%0d] a=%h b=%h s=%b: got q=%h r=%h expected q=%h r=%h", i, av, bv, sv, quo, rem, e.q, e.r);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_mid_reset;
        test_random;
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
